// File: rtl/uart_pkg.sv
// uart_pkg: shared receiver state type, oversampling constants and baud divisor helper
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} rx_state_t;
    localparam int OVERSAMPLE = 16;
    localparam logic [3:0] SAMPLE_A = 4'd7;
    localparam logic [3:0] SAMPLE_B = 4'd8;
    localparam logic [3:0] SAMPLE_C = 4'd9;
    function automatic int calc_div(input int clk_freq, input int baud);
        return clk_freq / (baud * OVERSAMPLE);
    endfunction
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: one-cycle 16x oversample tick every DIV clocks, realignable by restart
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600
) (
    input  logic clk,
    input  logic reset_n,
    input  logic restart,
    output logic tick
);
    localparam int DIV = calc_div(CLK_FREQ, BAUD) < 1 ? 1 : calc_div(CLK_FREQ, BAUD);
    localparam int W = DIV > 1 ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);
    logic [W-1:0] cnt;
    // free-running divider; a start edge pulls it back to zero so tick k lands k*DIV after the edge
    always_ff @(posedge clk) begin
        if (!reset_n || restart) cnt <= '0;
        else cnt <= tick ? '0 : cnt + 1'b1;
    end
    assign tick = cnt == LAST;
endmodule

// File: rtl/uart_rx_8n1.sv
// uart_rx_8n1: 8-N-1 serial receiver with 16x oversampling and 3-sample majority vote
module uart_rx_8n1
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       received,
    output logic       recv_error,
    output logic       is_receiving
);
    rx_state_t  state, state_n;
    logic       rx_meta, rx_sync, rx_prev;
    logic [1:0] warm;
    logic       tick, start_edge, vote_now, vote, load, err, shift;
    logic [3:0] tcnt, tnext;
    logic [2:0] bit_cnt;
    logic [1:0] smp;
    logic [7:0] shreg;

    uart_baud_tick #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) u_tick (
        .clk(clk), .reset_n(reset_n), .restart(start_edge), .tick(tick)
    );

    assign start_edge   = state == IDLE && rx_prev && !rx_sync;
    assign tnext        = tcnt + 4'd1;
    assign vote_now     = tick && tnext == SAMPLE_C;
    assign vote         = (smp[0] & smp[1]) | ((smp[0] | smp[1]) & rx_sync);
    assign is_receiving = state == DATA || state == STOP;

    // synchronizer and edge history; warm masks the synchronizer's reset value so a line low out of reset is no edge
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b0;
            warm    <= 2'b00;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            warm    <= {warm[0], 1'b1};
            rx_prev <= rx_sync & warm[1];
        end
    end

    // state register
    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else state <= state_n;
    end

    // next state and per-cycle actions, all decisions taken at the third sample of a bit
    always_comb begin
        state_n = state;
        load    = 1'b0;
        err     = 1'b0;
        shift   = 1'b0;
        case (state)
            IDLE:      state_n = start_edge ? START : IDLE;
            START:     if (vote_now) state_n = vote ? IDLE : DATA;
            DATA: if (vote_now) begin
                shift   = 1'b1;
                state_n = bit_cnt == 3'd7 ? STOP : DATA;
            end
            STOP: if (vote_now) begin
                load    = vote;
                err     = !vote;
                state_n = vote ? IDLE : WAIT_HIGH;
            end
            WAIT_HIGH: state_n = rx_sync ? IDLE : WAIT_HIGH;
            default:   state_n = IDLE;
        endcase
    end

    // oversample position, sample capture, shift register and registered result pulses
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rx_byte    <= 8'h00;
            received   <= 1'b0;
            recv_error <= 1'b0;
            shreg      <= 8'h00;
            bit_cnt    <= 3'd0;
            tcnt       <= 4'd0;
            smp        <= 2'b00;
        end else begin
            received   <= load;
            recv_error <= err;
            if (load) rx_byte <= shreg;
            if (shift) shreg <= {vote, shreg[7:1]};
            if (start_edge) begin
                tcnt    <= 4'd0;
                bit_cnt <= 3'd0;
            end else begin
                if (tick) tcnt <= tnext;
                if (shift) bit_cnt <= bit_cnt + 3'd1;
            end
            if (tick && tnext == SAMPLE_A) smp[0] <= rx_sync;
            if (tick && tnext == SAMPLE_B) smp[1] <= rx_sync;
        end
    end
endmodule

// File: tb/tb_uart_rx_8n1.sv
// tb_uart_rx_8n1: frame-level transmitter plus expected-event model checked every cycle
module tb_uart_rx_8n1;
    localparam int CLK_FREQ = 1_600_000;
    localparam int BAUD     = 10_000;
    localparam int BIT      = CLK_FREQ / BAUD;

    typedef struct packed {
        logic       err;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n, rx;
    logic [7:0] rx_byte;
    logic       received, recv_error, is_receiving;
    int         checks = 0;
    int         errors = 0;
    int         err_seen = 0;
    int         n0;
    exp_t       q[$];
    exp_t       e;
    logic [7:0] seen[$];
    logic [7:0] model_last = 8'h00;
    logic       prev_busy = 1'b0;
    logic       must_busy, must_idle;

    uart_rx_8n1 #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .clk(clk), .reset_n(reset_n), .rx(rx), .rx_byte(rx_byte),
        .received(received), .recv_error(recv_error), .is_receiving(is_receiving)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic line(input logic b, input int n);
        rx = b;
        repeat (n) @(negedge clk);
    endtask

    task automatic idle(input int n);
        must_idle = 1'b1;
        line(1'b1, n);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_ok);
        q.push_back({!stop_ok, d});
        must_idle = 1'b0;
        line(1'b0, 12 * BIT / 16);
        must_busy = 1'b1;
        line(1'b0, BIT - 12 * BIT / 16);
        for (int i = 0; i < 8; i++) line(d[i], BIT);
        line(stop_ok, BIT / 2);
        must_busy = 1'b0;
        line(stop_ok, BIT - BIT / 2);
    endtask

    // compare process: pulses must match the expected-event queue, rx_byte must equal the last good byte
    always @(posedge clk) begin
        #1;
        if (!reset_n) begin
            chk("reset_state", {rx_byte, received, recv_error, is_receiving}, 32'h0);
            model_last = 8'h00;
        end else begin
            chk("pulse_exclusive", {received, recv_error}, 2'b00 | (received ^ recv_error ? {received, recv_error} : 2'b00));
            if (received || recv_error) begin
                chk("busy_drop_at_pulse", {prev_busy, is_receiving}, 2'b10);
                chk("pulse_expected", q.size() > 0, 1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("pulse_kind", recv_error, e.err);
                    if (!e.err) model_last = e.data;
                end
                if (received) seen.push_back(rx_byte);
                if (recv_error) err_seen++;
            end
            chk("rx_byte_hold", rx_byte, model_last);
            if (must_busy) chk("is_receiving_high", is_receiving, 1);
            if (must_idle) chk("is_receiving_low", is_receiving, 0);
        end
        prev_busy = is_receiving;
    end

    initial begin
        rx = 1'b1;
        reset_n = 1'b0;
        must_busy = 1'b0;
        must_idle = 1'b0;
        repeat (5) @(negedge clk);
        reset_n = 1'b1;
        idle(2 * BIT);
        send_frame(8'h0D, 1'b1);
        idle(BIT);
        chk("frame_0d_byte", rx_byte, 8'h0D);
        chk("frame_0d_count", seen.size(), 1);
        send_frame(8'h31, 1'b1);
        send_frame(8'h32, 1'b1);
        idle(2 * BIT);
        chk("b2b_count", seen.size(), 3);
        chk("b2b_first", seen[1], 8'h31);
        chk("b2b_second", seen[2], 8'h32);
        chk("b2b_byte", rx_byte, 8'h32);
        must_idle = 1'b1;
        line(1'b0, 46);
        line(1'b1, 3 * BIT);
        chk("glitch_no_pulse", seen.size(), 3);
        chk("glitch_no_error", err_seen, 0);
        send_frame(8'h41, 1'b1);
        send_frame(8'h55, 1'b0);
        must_idle = 1'b1;
        line(1'b0, 5 * BIT);
        chk("framing_error_count", err_seen, 1);
        chk("framing_keeps_byte", rx_byte, 8'h41);
        idle(2 * BIT);
        send_frame(8'h42, 1'b1);
        idle(2 * BIT);
        chk("after_break_byte", rx_byte, 8'h42);
        chk("after_break_count", seen.size(), 5);
        must_idle = 1'b0;
        line(1'b0, 12 * BIT / 16);
        must_busy = 1'b1;
        line(1'b0, BIT - 12 * BIT / 16);
        for (int i = 0; i < 4; i++) line(i == 0 || i == 2, BIT);
        line(1'b0, BIT / 2);
        must_busy = 1'b0;
        reset_n = 1'b0;
        line(1'b0, 3);
        reset_n = 1'b1;
        must_idle = 1'b1;
        line(1'b0, BIT / 2 - 3);
        idle(2 * BIT);
        chk("abort_byte", rx_byte, 8'h00);
        chk("abort_no_pulse", seen.size(), 5);
        send_frame(8'h7E, 1'b1);
        idle(2 * BIT);
        chk("resume_byte", rx_byte, 8'h7E);
        n0 = seen.size();
        rx = 1'b0;
        reset_n = 1'b0;
        line(1'b0, 5);
        must_idle = 1'b1;
        reset_n = 1'b1;
        line(1'b0, 2 * BIT);
        idle(2 * BIT);
        send_frame(8'h30, 1'b1);
        idle(2 * BIT);
        chk("low_reset_one_pulse", seen.size() - n0, 1);
        chk("low_reset_byte", rx_byte, 8'h30);
        chk("pending_events", q.size(), 0);
        chk("total_errors", err_seen, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx_8n1.md
UART_RX_8N1 -- requirements
Module: uart_rx_8n1

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100_000_000, meaning the clk frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600, meaning the serial bit rate.
REQ-003 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port rx  input  1  asynchronous serial line, idle high, 8-N-1, LSB first.
REQ-006 SHALL have port rx_byte  output  8  last correctly framed byte.
REQ-007 SHALL have port received  output  1  one-cycle pulse: rx_byte just updated.
REQ-008 SHALL have port recv_error  output  1  one-cycle pulse: framing error (stop bit low).
REQ-009 SHALL have port is_receiving  output  1  high from validated start bit until frame end.

Function
REQ-010 SHALL pass rx through a 2-FF synchronizer before any use; both FFs reset to 1.
REQ-011 SHALL generate a 16x oversample tick every DIV = CLK_FREQ/(BAUD*16) clocks, integer floor (651 at defaults); the tick counter SHALL restart at 0 when a start edge is detected.
REQ-012 SHALL implement FSM states IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-013 IDLE: on a 1->0 transition of the synchronized line SHALL go to START; the previous-sample register resets to 0, so a line already low out of reset is not a start.
REQ-014 Each bit SHALL be resolved by majority vote of samples at oversample ticks 7, 8, 9 of that bit period (tick 0 = bit start).
REQ-015 START: after tick 9, a vote of 1 SHALL return to IDLE with no pulse (glitch reject); a vote of 0 SHALL go to DATA and assert is_receiving.
REQ-016 DATA: 8 bits, 16 ticks each, SHALL be shifted in LSB first; after the 8th bit's vote SHALL go to STOP.
REQ-017 STOP: after the stop-bit vote, 1 SHALL load rx_byte, pulse received for exactly one cycle on the next clock, and go to IDLE.
REQ-018 STOP: a vote of 0 SHALL pulse recv_error for one cycle, leave rx_byte unchanged, and go to WAIT_HIGH.
REQ-019 WAIT_HIGH: SHALL stay until the synchronized line is 1 (break condition held indefinitely), then go to IDLE without pulses.
REQ-020 is_receiving SHALL deassert in the same cycle received or recv_error pulses, or on return from START to IDLE.
REQ-021 received and recv_error SHALL never be high in the same cycle.
REQ-022 rx_byte SHALL hold its value between good frames; the shift register SHALL not be visible on rx_byte.
REQ-023 A new start edge SHALL be accepted in the first IDLE cycle after a good frame (back-to-back frames, no extra idle required beyond the stop bit half remaining).

Reset
REQ-024 On reset_n=0 at a clock edge: state IDLE, rx_byte=0x00, received=0, recv_error=0, is_receiving=0, tick and bit counters 0, synchronizer FFs 1, previous-sample 0.
REQ-025 Reset asserted mid-frame SHALL abandon the frame with no pulse; reception resumes at the next valid start edge after release.

Structure
REQ-026 Shared package uart_pkg SHALL hold the FSM state typedef, OVERSAMPLE=16, the sample tick indices 7/8/9, and the divisor computation function.
REQ-027 Oversample tick generator SHALL be the sub-module uart_baud_tick (params CLK_FREQ, BAUD; ports clk, reset_n, restart, tick).
REQ-028 uart_rx_8n1 SHALL be drop-in compatible with the received/rx_byte/recv_error/is_receiving contract of the existing uart wrapper.

Verification (bit time 10416 clocks at defaults)
REQ-029 Frame 0x0D (start, 1,0,1,1,0,0,0,0, stop) -> one received pulse, rx_byte=0x0D, recv_error never high.
REQ-030 Back-to-back 0x31 then 0x32, no idle gap -> two received pulses, rx_byte 0x31 then 0x32.
REQ-031 rx low for 3000 clocks then high -> no pulse, is_receiving stays 0, FSM back in IDLE.
REQ-032 Frame 0x55 with stop bit 0 after prior good 0x41 -> recv_error pulse, rx_byte stays 0x41; line held low 5 bit times then high, then frame 0x42 -> received, rx_byte=0x42.
REQ-033 reset_n pulsed during data bit 4 of 0xA5 -> no pulse, rx_byte=0x00; next frame 0x7E -> rx_byte=0x7E.
REQ-034 rx held low through reset release, then raised, then frame 0x30 -> only one received pulse, rx_byte=0x30.
